delay_window_checker: RTL and testbench

Synthesizable runtime monitor that implements the bounded-delay implication "a |-> ##[MIN_DLY:MAX_DLY] b" in RTL. It sits directly downstream of the `seq` waveform generators and consumes their `a`, `b` and `reset` bits. It produces per-cycle pass/fail pulses and saturating counters, so the same obligation can be checked in simulation, on FPGA, or cross-checked against the equivalent SVA assertion under formal.

---
 rtl/delay_check_pkg.sv | 21 ++
 rtl/sat_counter.sv | 34 +++
 rtl/delay_window_checker.sv | 102 ++++++++++
 tb/tb_delay_window_checker.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/delay_check_pkg.sv
// Shared constants and helpers for the bounded-delay implication monitor.
package delay_check_pkg;

    localparam int unsigned MAX_DEPTH = 32;
    localparam int unsigned POP_W     = 6;

    // Window must be ordered and fit in the MAX_DEPTH-deep age vector.
    function automatic bit dly_params_ok(input int unsigned min_dly, input int unsigned max_dly);
        return (min_dly <= max_dly) && (max_dly <= MAX_DEPTH - 1);
    endfunction

    function automatic logic [POP_W-1:0] popcount(input logic [MAX_DEPTH-1:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            n = n + POP_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a multi-bit increment; never wraps.
module sat_counter #(
    parameter int unsigned W     = 8,
    parameter int unsigned INC_W = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [INC_W-1:0] inc,
    output logic [W-1:0]     count
);

    localparam int unsigned     SUM_W = ((W > INC_W) ? W : INC_W) + 1;
    localparam logic [SUM_W-1:0] MAX_V = SUM_W'({W{1'b1}});

    logic [W-1:0]     count_q;
    logic [W-1:0]     count_d;
    logic [SUM_W-1:0] sum;

    always_comb begin
        sum     = SUM_W'(count_q) + SUM_W'(inc);
        count_d = (sum > MAX_V) ? W'(MAX_V) : W'(sum);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/delay_window_checker.sv
// Runtime monitor for "a |-> ##[MIN_DLY:MAX_DLY] b" with pass/fail pulses and counters.
module delay_window_checker
    import delay_check_pkg::*;
#(
    parameter int unsigned MIN_DLY = 1,
    parameter int unsigned MAX_DLY = 2,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             a,
    input  logic             b,
    output logic             pass,
    output logic             fail,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count,
    output logic             pending
);

    if (!dly_params_ok(MIN_DLY, MAX_DLY)) begin : g_bad_params
        $fatal(1, "delay_window_checker: need MIN_DLY <= MAX_DLY <= 31");
    end

    // pend_q[k]: obligation that survived at age k; it is seen at age k+1 next sample.
    logic [MAX_DLY:0]   pend_q;
    logic [MAX_DLY:0]   pend_d;
    logic [MAX_DLY:0]   ages;
    logic [MAX_DLY:0]   disch;
    logic [MAX_DEPTH-1:0] disch_ext;
    logic [POP_W-1:0]   pass_inc;
    logic               expire;
    logic               pass_q;
    logic               pass_d;
    logic               fail_q;
    logic               fail_d;

    for (genvar k = 0; k <= MAX_DLY; k++) begin : g_age
        if (k == 0) begin : g_launch
            assign ages[k] = a;
        end else begin : g_shift
            assign ages[k] = pend_q[k-1];
        end

        // Ages younger than the window are untouched by b.
        if (k >= MIN_DLY) begin : g_win
            assign disch[k] = ages[k] & b;
        end else begin : g_early
            assign disch[k] = 1'b0;
        end

        if (k < MAX_DLY) begin : g_keep
            assign pend_d[k] = ages[k] & ~disch[k];
        end else begin : g_last
            assign pend_d[k] = 1'b0;
        end
    end

    always_comb begin
        expire    = ages[MAX_DLY] & ~b;
        disch_ext = MAX_DEPTH'(disch);
        pass_inc  = popcount(disch_ext);
        pass_d    = |disch;
        fail_d    = expire;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pend_q <= '0;
            pass_q <= 1'b0;
            fail_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            pass_q <= pass_d;
            fail_q <= fail_d;
        end
    end

    sat_counter #(
        .W     (CNT_W),
        .INC_W (POP_W)
    ) u_pass_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (pass_inc),
        .count (pass_count)
    );

    sat_counter #(
        .W     (CNT_W),
        .INC_W (1)
    ) u_fail_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (fail_d),
        .count (fail_count)
    );

    assign pass    = pass_q;
    assign fail    = fail_q;
    assign pending = |pend_q;

endmodule

// File: tb/tb_delay_window_checker.sv
// Directed bench: default window, zero-width window, and 2-bit counter saturation.
module tb_delay_window_checker;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, a0, b0, pass0, fail0, pend0;
    logic [7:0] pc0, fc0;
    logic       rst1, a1, b1, pass1, fail1, pend1;
    logic [7:0] pc1, fc1;
    logic       rst2, a2, b2, pass2, fail2, pend2;
    logic [1:0] pc2, fc2;

    delay_window_checker #(.MIN_DLY(1), .MAX_DLY(2), .CNT_W(8)) u_dut0 (
        .clock(clk), .reset(rst0), .a(a0), .b(b0), .pass(pass0), .fail(fail0),
        .pass_count(pc0), .fail_count(fc0), .pending(pend0)
    );

    delay_window_checker #(.MIN_DLY(0), .MAX_DLY(0), .CNT_W(8)) u_dut1 (
        .clock(clk), .reset(rst1), .a(a1), .b(b1), .pass(pass1), .fail(fail1),
        .pass_count(pc1), .fail_count(fc1), .pending(pend1)
    );

    delay_window_checker #(.MIN_DLY(1), .MAX_DLY(2), .CNT_W(2)) u_dut2 (
        .clock(clk), .reset(rst2), .a(a2), .b(b2), .pass(pass2), .fail(fail2),
        .pass_count(pc2), .fail_count(fc2), .pending(pend2)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // pass and fail must never be high together on any instance.
    always @(negedge clk) begin
        checks++;
        if ((pass0 === 1'b1 && fail0 === 1'b1) || (pass1 === 1'b1 && fail1 === 1'b1) ||
            (pass2 === 1'b1 && fail2 === 1'b1)) begin
            failures++;
            $display("FAIL pass_fail_exclusive: got both high expected at most one (t=%0t)", $time);
        end
    end

    typedef struct {
        logic       rst, a, b;
        logic       pass, fail;
        logic [7:0] pc, fc;
        logic       pend;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic a, input logic b, input logic pass,
                       input logic fail, input logic [7:0] pc, input logic [7:0] fc,
                       input logic pend);
        vec_t v;
        v.rst = rst; v.a = a; v.b = b; v.pass = pass; v.fail = fail;
        v.pc = pc; v.fc = fc; v.pend = pend;
        vecs.push_back(v);
    endtask

    initial begin
        rst0 = 1'b1; a0 = 1'b0; b0 = 1'b0;
        rst1 = 1'b1; a1 = 1'b0; b1 = 1'b0;
        rst2 = 1'b1; a2 = 1'b0; b2 = 1'b0;

        // Row = inputs at one sample; expected outputs seen at the next sample.
        //   rst a  b   pass fail pc fc pend
        add(1, 0, 0,  0, 0, 0, 0, 0);
        add(0, 1, 0,  0, 0, 0, 0, 1);
        add(0, 0, 0,  0, 0, 0, 0, 1);
        add(0, 0, 1,  1, 0, 1, 0, 0);
        add(0, 0, 0,  0, 0, 1, 0, 0);
        add(0, 0, 0,  0, 0, 1, 0, 0);
        add(1, 1, 0,  0, 0, 0, 0, 0);
        add(0, 0, 0,  0, 0, 0, 0, 0);
        add(0, 1, 0,  0, 0, 0, 0, 1);
        add(0, 0, 0,  0, 0, 0, 0, 1);
        add(0, 0, 0,  0, 1, 0, 1, 0);
        add(0, 0, 1,  0, 0, 0, 1, 0);
        add(0, 0, 0,  0, 0, 0, 1, 0);
        add(0, 1, 0,  0, 0, 0, 1, 1);
        add(0, 1, 0,  0, 0, 0, 1, 1);
        add(0, 1, 0,  0, 1, 0, 2, 1);
        add(0, 0, 1,  1, 0, 2, 2, 0);
        add(0, 0, 0,  0, 0, 2, 2, 0);
        add(0, 1, 1,  0, 0, 2, 2, 1);
        add(0, 0, 1,  1, 0, 3, 2, 0);
        add(0, 0, 0,  0, 0, 3, 2, 0);
        add(0, 1, 0,  0, 0, 3, 2, 1);
        add(1, 0, 1,  0, 0, 0, 0, 0);
        add(0, 0, 0,  0, 0, 0, 0, 0);
        add(0, 0, 1,  0, 0, 0, 0, 0);
        add(0, 0, 0,  0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            rst0 = vecs[i].rst; a0 = vecs[i].a; b0 = vecs[i].b;
            tick();
            check($sformatf("v%0d pass", i), 32'(pass0), 32'(vecs[i].pass));
            check($sformatf("v%0d fail", i), 32'(fail0), 32'(vecs[i].fail));
            check($sformatf("v%0d pass_count", i), 32'(pc0), 32'(vecs[i].pc));
            check($sformatf("v%0d fail_count", i), 32'(fc0), 32'(vecs[i].fc));
            check($sformatf("v%0d pending", i), 32'(pend0), 32'(vecs[i].pend));
        end
        rst0 = 1'b1; a0 = 1'b0; b0 = 1'b0;

        // Zero-width window: a and b in the same sample discharge immediately.
        rst1 = 1'b1; tick();
        rst1 = 1'b0;
        for (int s = 1; s <= 4; s++) tick();
        a1 = 1'b1; b1 = 1'b1; tick();
        check("z0 pass", 32'(pass1), 32'd1);
        check("z0 fail", 32'(fail1), 32'd0);
        check("z0 pass_count", 32'(pc1), 32'd1);
        check("z0 pending", 32'(pend1), 32'd0);
        a1 = 1'b0; b1 = 1'b0; tick();
        check("z0 pass_drop", 32'(pass1), 32'd0);
        tick();
        a1 = 1'b1; tick();
        check("z0 fail_hit", 32'(fail1), 32'd1);
        check("z0 fail_nopass", 32'(pass1), 32'd0);
        check("z0 fail_count", 32'(fc1), 32'd1);
        check("z0 fail_pending", 32'(pend1), 32'd0);
        a1 = 1'b0; b1 = 1'b1; tick();
        check("z0 lone_b_pass", 32'(pass1), 32'd0);
        check("z0 lone_b_fail", 32'(fail1), 32'd0);
        check("z0 lone_b_count", 32'(pc1), 32'd1);
        b1 = 1'b0; rst1 = 1'b1;

        // 2-bit counters: five straight failures stick at 3, then pass saturates too.
        rst2 = 1'b1; tick();
        rst2 = 1'b0;
        for (int s = 1; s <= 8; s++) begin
            int n;
            a2 = (s <= 5);
            tick();
            n = (s >= 3) ? ((s - 2 > 5) ? 5 : s - 2) : 0;
            check($sformatf("s%0d fail", s), 32'(fail2), 32'((s >= 3 && s <= 7) ? 1 : 0));
            check($sformatf("s%0d fail_count", s), 32'(fc2), 32'((n > 3) ? 3 : n));
        end
        a2 = 1'b1; tick(); tick();
        a2 = 1'b0; b2 = 1'b1; tick();
        check("s_pass_two", 32'(pass2), 32'd1);
        check("s_pass_count2", 32'(pc2), 32'd2);
        a2 = 1'b1; b2 = 1'b0; tick(); tick();
        a2 = 1'b0; b2 = 1'b1; tick();
        check("s_pass_sat", 32'(pass2), 32'd1);
        check("s_pass_count_sat", 32'(pc2), 32'd3);
        check("s_fail_count_hold", 32'(fc2), 32'd3);
        b2 = 1'b0; tick();
        check("s_pass_count_hold", 32'(pc2), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
